// File: rtl/perspective_undivide.sv
// rtl/perspective_undivide.sv - NDC (x/w,y/w,z/w,1/w) to clip-space (x,y,z,w) via shared fp32 div/mul
// Optional macro PERSPECTIVE_UNDIVIDE_ZERO_GUARD_EN: 1/w with zero exponent returns zeros with error_out set.

module fp32_mul #(parameter int LAT = 2) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [31:0] result
);
  logic [23:0] ma, mb, frac_r;
  logic [47:0] prod;
  logic [22:0] frac;
  logic        guard, sticky, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [9:0]  exp_s;
  logic [31:0] res;
  logic [LAT-1:0] vpipe;
  logic [31:0] dpipe [LAT];

  always_comb begin
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    prod = {24'b0, ma} * {24'b0, mb};
    a_zero = a[30:23] == 8'h00;
    b_zero = b[30:23] == 8'h00;
    a_inf = a[30:23] == 8'hFF && a[22:0] == 23'b0;
    b_inf = b[30:23] == 8'hFF && b[22:0] == 23'b0;
    a_nan = a[30:23] == 8'hFF && a[22:0] != 23'b0;
    b_nan = b[30:23] == 8'hFF && b[22:0] != 23'b0;
    if (prod[47]) begin
      frac = prod[46:24]; guard = prod[23]; sticky = |prod[22:0];
    end else begin
      frac = prod[45:23]; guard = prod[22]; sticky = |prod[21:0];
    end
    frac_r = {1'b0, frac} + {23'b0, guard & (sticky | frac[0])};
    exp_s = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'b0, prod[47]} + {9'b0, frac_r[23]};
    res = {a[31] ^ b[31], exp_s[7:0], frac_r[22:0]};
    // Denormals are flushed to zero on input and output
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = 32'h7FC00000;
    else if (a_inf || b_inf) res = {a[31] ^ b[31], 8'hFF, 23'b0};
    else if (a_zero || b_zero || exp_s[9] || exp_s == 10'd0) res = {a[31] ^ b[31], 31'b0};
    else if (exp_s >= 10'd255) res = {a[31] ^ b[31], 8'hFF, 23'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vpipe <= '0;
    else begin
      vpipe[0] <= valid_in;
      for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dpipe[0] <= res;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end

  assign valid_out = vpipe[LAT-1];
  assign result = dpipe[LAT-1];
endmodule

module fp32_div #(parameter int LAT = 3) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [31:0] result
);
  logic [49:0] num, den;
  logic [26:0] q;
  logic [23:0] rem, frac_r;
  logic [22:0] frac;
  logic        guard, sticky, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [9:0]  exp_s;
  logic [31:0] res;
  logic [LAT-1:0] vpipe;
  logic [31:0] dpipe [LAT];

  always_comb begin
    num = {1'b1, a[22:0], 26'b0};
    den = {26'b0, 1'b1, b[22:0]};
    q = 27'(num / den);
    rem = 24'(num % den);
    a_zero = a[30:23] == 8'h00;
    b_zero = b[30:23] == 8'h00;
    a_inf = a[30:23] == 8'hFF && a[22:0] == 23'b0;
    b_inf = b[30:23] == 8'hFF && b[22:0] == 23'b0;
    a_nan = a[30:23] == 8'hFF && a[22:0] != 23'b0;
    b_nan = b[30:23] == 8'hFF && b[22:0] != 23'b0;
    if (q[26]) begin
      frac = q[25:3]; guard = q[2]; sticky = (|q[1:0]) | (|rem);
    end else begin
      frac = q[24:2]; guard = q[1]; sticky = q[0] | (|rem);
    end
    frac_r = {1'b0, frac} + {23'b0, guard & (sticky | frac[0])};
    exp_s = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd126 + {9'b0, q[26]} + {9'b0, frac_r[23]};
    res = {a[31] ^ b[31], exp_s[7:0], frac_r[22:0]};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) res = 32'h7FC00000;
    else if (a_inf || b_zero) res = {a[31] ^ b[31], 8'hFF, 23'b0};
    else if (a_zero || b_inf || exp_s[9] || exp_s == 10'd0) res = {a[31] ^ b[31], 31'b0};
    else if (exp_s >= 10'd255) res = {a[31] ^ b[31], 8'hFF, 23'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vpipe <= '0;
    else begin
      vpipe[0] <= valid_in;
      for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dpipe[0] <= res;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end

  assign valid_out = vpipe[LAT-1];
  assign result = dpipe[LAT-1];
endmodule

module perspective_undivide (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0][31:0] vertex_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [3:0][31:0] vertex_out,
  output logic             error_out
);
  localparam int DIV_LAT = 3;
  localparam int MUL_LAT = 2;

  typedef enum logic [1:0] {IDLE, RECIP, MUL, DONE} state_t;
  state_t state_q, state_d;

  logic [3:0][31:0] in_q, out_q;
  logic        alive_q, div_sent_q, div_go, mul_go, div_vout, mul_vout, accept, zero_w;
  logic [1:0]  iss_cnt_q, res_cnt_q;
  logic [31:0] div_res, mul_res;

  fp32_div #(.LAT(DIV_LAT)) u_div (
    .clk(clk_in), .rst(rst_in), .valid_in(div_go), .a(32'h3F800000), .b(in_q[3]),
    .valid_out(div_vout), .result(div_res)
  );

  // out_q[3] holds w once RECIP completes and doubles as the multiplier operand
  fp32_mul #(.LAT(MUL_LAT)) u_mul (
    .clk(clk_in), .rst(rst_in), .valid_in(mul_go), .a(in_q[iss_cnt_q]), .b(out_q[3]),
    .valid_out(mul_vout), .result(mul_res)
  );

  assign ready_out  = alive_q && state_q == IDLE;
  assign accept     = valid_in && ready_out;
  assign valid_out  = state_q == DONE;
  assign vertex_out = out_q;

`ifdef PERSPECTIVE_UNDIVIDE_ZERO_GUARD_EN
  logic err_q;
  assign zero_w    = vertex_in[3][30:23] == 8'h00;
  assign error_out = err_q;
`else
  assign zero_w    = 1'b0;
  assign error_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    div_go  = 1'b0;
    mul_go  = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = zero_w ? DONE : RECIP;
      RECIP: begin
        div_go = !div_sent_q;
        if (div_vout) state_d = MUL;
      end
      MUL: begin
        mul_go = iss_cnt_q != 2'd3;
        if (mul_vout && res_cnt_q == 2'd2) state_d = DONE;
      end
      DONE:  if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alive_q    <= 1'b0;
      in_q       <= '0;
      out_q      <= '0;
      div_sent_q <= 1'b0;
      iss_cnt_q  <= 2'd0;
      res_cnt_q  <= 2'd0;
`ifdef PERSPECTIVE_UNDIVIDE_ZERO_GUARD_EN
      err_q      <= 1'b0;
`endif
    end else begin
      alive_q <= 1'b1;
      case (state_q)
        IDLE: if (accept) begin
          in_q       <= vertex_in;
          div_sent_q <= 1'b0;
          iss_cnt_q  <= 2'd0;
          res_cnt_q  <= 2'd0;
`ifdef PERSPECTIVE_UNDIVIDE_ZERO_GUARD_EN
          if (zero_w) begin
            out_q <= '0;
            err_q <= 1'b1;
          end
`endif
        end
        RECIP: begin
          if (div_go) div_sent_q <= 1'b1;
          if (div_vout) out_q[3] <= div_res;
        end
        MUL: begin
          if (mul_go) iss_cnt_q <= iss_cnt_q + 2'd1;
          if (mul_vout) begin
            out_q[res_cnt_q] <= mul_res;
            res_cnt_q        <= res_cnt_q + 2'd1;
          end
        end
        DONE: begin
`ifdef PERSPECTIVE_UNDIVIDE_ZERO_GUARD_EN
          if (ready_in) err_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
